// File: rtl/shift_sequencer_32_pkg.sv
// Encodings and sizes for the multi-cycle shift unit.
// The decoder and the bench use this package as well.
package fusion_shift_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_SLL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_sequencer_32_if.sv
// Request/result handshake bundle for shift_sequencer_32.
// The master is the issuing stage; the slave is the shift unit.
interface shift_sequencer_32_if;
    import fusion_shift_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_result;

    modport master (
        output in_valid, in_a, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_a, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_result
    );

endinterface

// File: rtl/shift_sequencer_32_step.sv
// One single-bit shift or rotate step, combinational.
// The sequencer applies it once per clock.
module shift_step_32
    import fusion_shift_pkg::*;
(
    input  logic [WIDTH-1:0] work_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] work_o
);

    always_comb begin
        work_o = work_i;
        case (op_i)
            OP_SRL:  work_o = {1'b0, work_i[WIDTH-1:1]};
            OP_SRA:  work_o = {work_i[WIDTH-1], work_i[WIDTH-1:1]};
            OP_SLL:  work_o = {work_i[WIDTH-2:0], 1'b0};
            OP_ROR:  work_o = {work_i[0], work_i[WIDTH-1:1]};
            default: work_o = work_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer_32.sv
// Sequential shifter: it applies one bit of shift per clock.
// The result appears shamt+1 cycles after accept and is held until it is consumed.
module shift_sequencer_32
    import fusion_shift_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    output logic                 busy,
    shift_sequencer_32_if.slave  bus
);

    // state    | meaning
    // ST_IDLE  | waiting for a request, in_ready high unless flushing
    // ST_SHIFT | one step per clock until count reaches zero
    // ST_DONE  | result presented, waiting for out_ready

    state_e             state_q;
    op_e                op_q;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   work_d;
    logic [SHAMT_W-1:0] count_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_result_q;

    shift_step_32 u_step (
        .work_i (work_q),
        .op_i   (op_q),
        .work_o (work_d)
    );

    assign bus.in_ready   = (state_q == ST_IDLE) && !flush;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign busy           = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_SRL;
            work_q       <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else if (flush) begin
            // Flush beats a same-cycle output handshake: the result is dropped.
            state_q      <= ST_IDLE;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state_q <= ST_SHIFT;
                        work_q  <= bus.in_a;
                        count_q <= bus.in_shamt;
                        op_q    <= op_e'(bus.in_op);
                    end
                end
                ST_SHIFT: begin
                    if (count_q == '0) begin
                        state_q      <= ST_DONE;
                        out_valid_q  <= 1'b1;
                        out_result_q <= work_q;
                    end else begin
                        work_q  <= work_d;
                        count_q <= count_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q      <= ST_IDLE;
                        out_valid_q  <= 1'b0;
                        out_result_q <= '0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer_32.sv
// Bench for shift_sequencer_32: directed cases with literal expectations, then random traffic.
// A transaction-level reference model is compared against the unit on every cycle.
module tb_shift_sequencer_32;
    import fusion_shift_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;

    shift_sequencer_32_if bus ();

    shift_sequencer_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_fn(input logic [1:0] op, input logic [31:0] a, input int s);
        logic signed [31:0] sa;
        logic [63:0]        d;
        sa = a;
        d  = {a, a} >> s;
        case (op)
            OP_SRL:  return a >> s;
            OP_SRA:  return sa >>> s;
            OP_SLL:  return a << s;
            default: return d[31:0];
        endcase
    endfunction

    // Transaction model: a request is pending from its accept until it is consumed or flushed.
    // Its result becomes visible shamt+1 edges after the accept.
    int          cyc = 0;
    int          m_due = 0;
    bit          m_pending = 1'b0;
    logic [31:0] m_res = '0;
    bit          v_pre;
    bit          e_valid;

    initial begin : monitor
        forever begin
            @(posedge clk);
            v_pre = m_pending && (cyc >= m_due);
            cyc++;
            if (!rst_n || flush) begin
                m_pending = 1'b0;
            end else if (!m_pending) begin
                if (bus.in_valid) begin
                    m_pending = 1'b1;
                    m_due     = cyc + int'(bus.in_shamt) + 1;
                    m_res     = ref_fn(bus.in_op, bus.in_a, int'(bus.in_shamt));
                end
            end else if (v_pre && bus.out_ready) begin
                m_pending = 1'b0;
            end
            #1;
            e_valid = m_pending && (cyc >= m_due);
            check("mon_busy", 32'(busy), 32'(m_pending));
            check("mon_out_valid", 32'(bus.out_valid), 32'(e_valid));
            check("mon_out_result", bus.out_result, e_valid ? m_res : 32'h0);
            if (rst_n) check("mon_in_ready", 32'(bus.in_ready), 32'(!m_pending && !flush));
        end
    end

    // Caller must be at a negedge; for hold=0 the task returns at a negedge.
    task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] s, input logic [31:0] exp_res, input int exp_lat,
                          input bit hold);
        int lat;
        lat = 0;
        for (int i = 0; i < 50 && !bus.in_ready; i++) @(negedge clk);
        check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_shamt  = s;
        bus.in_op     = op;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_shamt = 5'($urandom);
        bus.in_op    = 2'($urandom);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, bus.out_result, exp_res);
        if (!hold) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    logic [31:0] held;
    bit          saw_valid;

    initial begin : main
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_shamt  = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;

        check("model_sra", ref_fn(OP_SRA, 32'h8000_0000, 4), 32'hF800_0000);
        check("model_ror", ref_fn(OP_ROR, 32'h0000_0001, 1), 32'h8000_0000);
        check("model_sll", ref_fn(OP_SLL, 32'h0000_0001, 31), 32'h8000_0000);

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        do_req("sra4", OP_SRA, 32'h8000_0000, 5'd4, 32'hF800_0000, 5, 1'b0);
        do_req("srl4", OP_SRL, 32'h8000_0000, 5'd4, 32'h0800_0000, 5, 1'b0);
        do_req("sll31", OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 1'b0);
        for (int op = 0; op < 4; op++)
            do_req($sformatf("zero_op%0d", op), 2'(op), 32'h1234_5678, 5'd0, 32'h1234_5678, 1, 1'b0);
        do_req("ror1", OP_ROR, 32'h0000_0001, 5'd1, 32'h8000_0000, 2, 1'b0);

        // Backpressure: the result is held for 10 cycles, then a back-to-back request follows.
        do_req("bp", OP_SLL, 32'h0000_00A5, 5'd3, 32'h0000_0528, 4, 1'b1);
        held = bus.out_result;
        repeat (10) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_result", bus.out_result, held);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_after_in_ready", 32'(bus.in_ready), 32'd1);
        do_req("b2b", OP_SRA, 32'h4000_0000, 5'd2, 32'h1000_0000, 3, 1'b0);

        // Flush in the second shift cycle of an 8-step shift.
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h0000_0003;
        bus.in_shamt = 5'd8;
        bus.in_op    = OP_SLL;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", 32'(busy), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            saw_valid |= bus.out_valid;
        end
        check("flush_no_valid", 32'(saw_valid), 32'd0);
        @(negedge clk);
        do_req("post_flush", OP_SRL, 32'hF0F0_0000, 5'd8, 32'h00F0_F000, 9, 1'b0);

        // Asynchronous reset in the middle of a 20-step shift.
        bus.in_valid = 1'b1;
        bus.in_a     = 32'hFFFF_FFFF;
        bus.in_shamt = 5'd20;
        bus.in_op    = OP_SRL;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_result", bus.out_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        do_req("post_rst", OP_ROR, 32'h0000_0001, 5'd1, 32'h8000_0000, 2, 1'b0);

        // Random traffic, including flush against accepts and handshakes.
        repeat (2500) begin
            @(negedge clk);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_a      = $urandom;
            bus.in_shamt  = 5'($urandom);
            bus.in_op     = 2'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 29) == 0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        flush         = 1'b0;
        repeat (40) @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
